// File: rtl/branch_pkg.sv
// Shared types and constants for the gshare branch predictor.
package branch_pkg;
  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t SNT = 2'b00;
  localparam pht_cnt_t WNT = 2'b01;
  localparam pht_cnt_t WT  = 2'b10;
  localparam pht_cnt_t ST  = 2'b11;

  localparam pht_cnt_t PHT_DEFAULT = WNT;
endpackage

// File: rtl/branch_global_dpath_if.sv
// Fetch/resolve/control-facing signals of the global predictor datapath.
interface branch_global_dpath_if #(parameter int IDX_W = 11);
  logic             req_val;
  logic [31:0]      req_pc;
  logic             resp_val;
  logic             resp_taken;
  logic [IDX_W-1:0] resp_hist;
  logic             update_en;
  logic             update_val;
  logic [31:0]      update_pc;
  logic [IDX_W-1:0] update_hist;
  logic             increment_entry;
  logic             decrement_entry;
  logic             update_ghr;
  logic             entry_upper_reached;
  logic             entry_lower_reached;

  modport slave (
    input  req_val, req_pc, update_en, update_val, update_pc, update_hist,
           increment_entry, decrement_entry, update_ghr,
    output resp_val, resp_taken, resp_hist, entry_upper_reached, entry_lower_reached
  );

  modport master (
    output req_val, req_pc, update_en, update_val, update_pc, update_hist,
           increment_entry, decrement_entry, update_ghr,
    input  resp_val, resp_taken, resp_hist, entry_upper_reached, entry_lower_reached
  );
endinterface

// File: rtl/branch_pht_array.sv
// Pattern history table: two async read ports, one write port, reset to WNT.
module branch_pht_array
  import branch_pkg::*;
#(
  parameter  int PHT_size = 2048,
  localparam int IDX_W    = $clog2(PHT_size)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output pht_cnt_t         rd_cnt,
  input  logic [IDX_W-1:0] upd_idx,
  output pht_cnt_t         upd_cnt,
  input  logic             wr_en,
  input  pht_cnt_t         wr_cnt
);
  pht_cnt_t mem [PHT_size];

  assign rd_cnt  = mem[rd_idx];
  assign upd_cnt = mem[upd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_size; i++) mem[i] <= PHT_DEFAULT;
    end else if (wr_en) begin
      mem[upd_idx] <= wr_cnt;
    end
  end
endmodule

// File: rtl/branch_global_dpath.sv
// gshare datapath: GHR, index hashing, registered prediction, counter updates.
module branch_global_dpath
  import branch_pkg::*;
#(
  parameter  int PHT_size = 2048,
  localparam int IDX_W    = $clog2(PHT_size)
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_global_dpath_if.slave  bus
);
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] pred_idx, upd_idx;
  pht_cnt_t         pred_cnt, upd_cnt, wr_cnt;
  logic             wr_en;
  logic             resp_val, resp_taken;
  logic [IDX_W-1:0] resp_hist;

  assign pred_idx = bus.req_pc[IDX_W+1:2] ^ ghr;
  assign upd_idx  = bus.update_pc[IDX_W+1:2] ^ bus.update_hist;

  // Control owns saturation; the ST/SNT guards just keep a stray command from wrapping.
  always_comb begin
    wr_en  = 1'b0;
    wr_cnt = upd_cnt;
    if (bus.increment_entry && !bus.decrement_entry && upd_cnt != ST) begin
      wr_en  = 1'b1;
      wr_cnt = upd_cnt + 2'd1;
    end else if (bus.decrement_entry && !bus.increment_entry && upd_cnt != SNT) begin
      wr_en  = 1'b1;
      wr_cnt = upd_cnt - 2'd1;
    end
  end

  branch_pht_array #(.PHT_size(PHT_size)) u_pht (
    .clk     (clk),
    .rst_n   (reset),
    .rd_idx  (pred_idx),
    .rd_cnt  (pred_cnt),
    .upd_idx (upd_idx),
    .upd_cnt (upd_cnt),
    .wr_en   (wr_en),
    .wr_cnt  (wr_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr        <= '0;
      resp_val   <= 1'b0;
      resp_taken <= 1'b0;
      resp_hist  <= '0;
    end else begin
      resp_val <= bus.req_val;
      if (bus.req_val) begin
        resp_taken <= pred_cnt[1];
        resp_hist  <= ghr;
      end
      if (bus.update_ghr) ghr <= {ghr[IDX_W-2:0], bus.update_val};
    end
  end

  assign bus.resp_val            = resp_val;
  assign bus.resp_taken          = resp_taken;
  assign bus.resp_hist           = resp_hist;
  assign bus.entry_upper_reached = (upd_cnt == ST);
  assign bus.entry_lower_reached = (upd_cnt == SNT);

  // Only the index bits of the PCs matter; update_en is consumed by control.
  logic unused;
  assign unused = ^{bus.update_en, bus.req_pc[31:IDX_W+2], bus.req_pc[1:0],
                    bus.update_pc[31:IDX_W+2], bus.update_pc[1:0]};

  a_inc_dec_excl: assert property (@(posedge clk) disable iff (!reset)
    !(bus.increment_entry && bus.decrement_entry));
endmodule

// File: doc/branch_global_dpath.md
Name: branch_global_dpath

Overview:
Datapath for the global (gshare) branch predictor, directly downstream of the global branch control unit. It holds the pattern history table (PHT) of 2-bit saturating counters and the global history register (GHR). It serves registered prediction lookups from fetch. It also computes the update index, drives the entry_upper_reached/entry_lower_reached status to the control unit, and applies the increment_entry/decrement_entry/update_ghr commands it returns.

Parameters:
PHT_size, 2048, number of PHT entries; power of two, >= 4
IDX_W, $clog2(PHT_size), index width; GHR width equals IDX_W

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_val  in  1  prediction request valid
req_pc  in  32  PC of branch to predict
resp_val  out  1  prediction response valid, one cycle after req_val
resp_taken  out  1  predicted direction (counter MSB)
resp_hist  out  IDX_W  GHR snapshot used for this prediction; carried by pipeline to update
update_en  in  1  branch resolved this cycle (shared with control unit)
update_val  in  1  actual direction (1 = taken; shared with control unit)
update_pc  in  32  PC of resolved branch
update_hist  in  IDX_W  resp_hist returned with resolved branch
increment_entry  in  1  from control: increment PHT[upd_idx]
decrement_entry  in  1  from control: decrement PHT[upd_idx]
update_ghr  in  1  from control: shift update_val into GHR
entry_upper_reached  out  1  PHT[upd_idx] == 2'b11 (combinational)
entry_lower_reached  out  1  PHT[upd_idx] == 2'b00 (combinational)

Behaviour:
- Index functions:
  - pred_idx = req_pc[IDX_W+1:2] XOR ghr.
  - upd_idx = update_pc[IDX_W+1:2] XOR update_hist.
- Reset (reset==0, async):
  - all PHT entries = 2'b01 (weakly not-taken); ghr = 0.
  - resp_val = 0, resp_taken = 0, resp_hist = 0.
  - Reset asserted mid-operation discards any in-flight response.
- Prediction, 1-cycle latency, no backpressure:
  - On posedge, resp_val <= req_val.
  - When req_val=1: resp_taken <= PHT[pred_idx][1]; resp_hist <= ghr.
  - When req_val=0: resp_taken and resp_hist hold their values.
- Status outputs are pure combinational functions of PHT[upd_idx], valid every cycle regardless of update_en. This is required because the control unit is combinational and closes a same-cycle loop.
- Update, on posedge:
  - increment_entry=1: PHT[upd_idx] <= PHT[upd_idx]+1.
  - decrement_entry=1: PHT[upd_idx] <= PHT[upd_idx]-1.
  - update_ghr=1: ghr <= {ghr[IDX_W-2:0], update_val}.
- Saturation is decided by the control unit. The datapath also never wraps: increment at 2'b11 and decrement at 2'b00 are ignored (defensive).
- increment_entry and decrement_entry both 1 is illegal; the datapath performs no PHT write and asserts in simulation.
- Same-cycle collision, prediction and update to the same entry: the prediction reads the pre-update counter (read-before-write).
- A prediction in the same cycle as update_ghr uses the pre-shift ghr, and resp_hist reflects the pre-shift value.
- The GHR shift wraps naturally; the MSB is discarded.
- Counter states: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T. Predict taken iff MSB = 1.

Decomposition:
- Shared package branch_pkg:
  - counter state constants SNT/WNT/WT/ST (2-bit);
  - PHT_DEFAULT = WNT;
  - typedef pht_cnt_t (logic [1:0]).
- One natural sub-module: branch_pht_array, with:
  - one combinational read port for prediction;
  - one combinational read port for update plus a write port;
  - the async reset-to-WNT loop.
- GHR, index XOR, and response registers live in the top module.

Test Plan:
- Reset, then req_val=1, req_pc=0x100 -> next cycle resp_val=1, resp_taken=0, resp_hist=0; entry_lower_reached=0, entry_upper_reached=0 for any upd_idx.
- increment_entry=1, update_ghr=1, update_val=1 at update_pc=0x100, update_hist=0 for two cycles:
  - entry_upper_reached rises after the 2nd cycle (01->10->11);
  - ghr = 0b11;
  - a request at pc=0x100 with ghr=0 path uses the new index.
- decrement_entry=1 at the same index from WNT -> entry_lower_reached=1 after one cycle; further decrement_entry leaves the counter at 00 (no wrap to 11).
- Same-cycle request and increment to the same entry at counter 01 -> resp_taken=0 this response; the next request to that entry gives resp_taken=1.
- update_ghr=1 with update_val=1, repeated IDX_W+1 times -> ghr all ones, oldest bit discarded; a concurrent request's resp_hist shows the pre-shift value.
- Reset pulsed low mid-stream, with req_val=1 pending and counters modified -> resp_val=0 immediately (async), all entries back to 01, ghr=0.
